ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on posedge clk.
REQ-002 SHALL have ports: reset_  in  1  reset, synchronous, active-high (reset_=1 resets on the next posedge clk).
REQ-003 SHALL have ports: start  in  1  one-cycle request from the EX stage to begin a mult/div.
REQ-004 SHALL have ports: md_op  in  2  operation select: MULT, MULTU, DIV or DIVU.
REQ-005 SHALL have ports: rs_data  in  32  operand A (multiplicand or dividend).
REQ-006 SHALL have ports: rt_data  in  32  operand B (multiplier or divisor).
REQ-007 SHALL have ports: flush  in  1  abort of the in-flight operation.
REQ-008 SHALL have ports: hi_we, lo_we  in  1 each  MTHI/MTLO write enables.
REQ-009 SHALL have ports: wdata  in  32  MTHI/MTLO write data.
REQ-010 SHALL have ports: busy  out  1  stall request to the hazard unit.
REQ-011 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports: hi, lo  out  32 each  architectural HI/LO registers, read by MFHI/MFLO.

Function
REQ-013 SHALL be an FSM with states IDLE, MUL, DIV and DONE; busy = (state != IDLE); done = (state == DONE).
REQ-014 SHALL accept start only in IDLE, latching the operands and md_op: MULT/MULTU -> MUL, DIV/DIVU -> DIV.
REQ-015 SHALL ignore start while busy, with no effect on the running operation.
REQ-016 SHALL multiply by iterative radix-2 shift-add on operand magnitudes.
- Signed ops take two's-complement magnitudes.
- The 64-bit product is negated when the operand signs differ.
REQ-017 SHALL divide by iterative restoring division on operand magnitudes.
- Quotient is negative iff the signs differ (signed ops).
- Remainder takes the sign of the dividend.
REQ-018 SHALL run MUL and DIV for exactly 32 cycles, counted by a 5-bit counter 0..31.
- The edge at count 31 loads hi/lo with the result and enters DONE.
- busy is therefore high for 33 cycles after start is accepted.
REQ-019 SHALL place {hi,lo} = 64-bit product; lo = quotient; hi = remainder.
REQ-020 SHALL treat divisor == 0 as follows:
- The edge after acceptance goes directly to DONE, with lo = 32'hFFFF_FFFF and hi = rs_data.
- busy is high for 1 cycle.
REQ-021 SHALL return, for signed DIV 0x8000_0000 / 0xFFFF_FFFF, lo = 0x8000_0000 and hi = 0 (no trap).
REQ-022 SHALL always leave DONE for IDLE after one cycle.
REQ-023 SHALL, on flush in MUL or DIV, go to IDLE on the next edge.
- hi/lo are left unchanged and done is not pulsed.
- flush in IDLE or DONE has no effect.
REQ-024 SHALL write hi_we/lo_we only when state == IDLE; they are ignored otherwise.
REQ-025 SHALL apply a write that arrives in the same cycle as an accepted start.
- The operation's result later overwrites it.
REQ-026 SHALL take the operands from the latched copies; rs_data/rt_data changes after acceptance have no effect.

Reset
REQ-027 SHALL, on reset_=1 at posedge clk, set state = IDLE, counter = 0, hi = lo = 0, busy = 0 and done = 0, clearing all working registers.
REQ-028 SHALL give reset priority over start, flush and hi/lo writes.
- Reset mid-operation discards the operation; no done pulse is produced.

Structure
REQ-029 SHALL take its shared constants from defines.v:
- MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11.
- MD_ITER = 32 and the FSM state encodings.
- Existing DataBus and ENABLED/DISABLED macros.
REQ-030 SHALL be a single module with no sub-modules.
- Datapath: shared 64-bit accumulator/remainder register, 32-bit operand register, sign flags.

Verification
REQ-031 SHALL cover: MULT, rs = 0xFFFF_FFFF, rt = 2 -> busy for 33 cycles, one done pulse, hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFE.
REQ-032 SHALL cover: MULTU, rs = rt = 0xFFFF_FFFF -> hi = 0xFFFF_FFFE, lo = 0x0000_0001.
REQ-033 SHALL cover: DIV, rs = -7, rt = 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF; a second start issued while busy is ignored.
REQ-034 SHALL cover: DIVU, rs = 7, rt = 0 -> busy for 1 cycle, hi = 7, lo = 0xFFFF_FFFF.
REQ-035 SHALL cover: MTHI 0x1234 in IDLE, then DIVU 100/3 flushed at count 10 -> busy low next cycle, no done, hi = 0x1234 retained.
REQ-036 SHALL cover: reset_ = 1 at count 20 of MULT -> next cycle busy = 0, hi = lo = 0, no done.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the EX-stage multiply/divide unit.
//   - operation encodings for md_op
//   - iteration count and counter width
//   - FSM state encoding and the {hi,lo} result payload
package ex_muldiv_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ACC_W   = 2 * DATA_W;
  localparam int unsigned MD_ITER = 32;
  localparam int unsigned CNT_W   = 5;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic ENABLED  = 1'b1;
  localparam logic DISABLED = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // Two's-complement magnitude of a signed operand; unsigned operands pass through.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x,
                                            input logic              is_signed);
    return (is_signed && x[DATA_W-1]) ? (~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset_          clock and synchronous active-high reset
//   start, md_op         begin MULT/MULTU/DIV/DIVU (accepted only when idle)
//   rs_data, rt_data     operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   flush                abort the in-flight operation
//   hi_we, lo_we, wdata  MTHI/MTLO writes (honoured only when idle)
//   busy, done           stall request and one-cycle completion pulse
//   hi, lo               HI/LO registers
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic [1:0]        md_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;    // product accumulator, or {remainder, quotient}
  logic [DATA_W-1:0] opb;    // multiplicand or divisor magnitude
  logic              neg_q;  // negate product / quotient
  logic              neg_r;  // negate remainder

  // Operand decode at acceptance
  logic              is_signed_c;
  logic              is_div_c;
  logic [DATA_W-1:0] a_mag_c;
  logic [DATA_W-1:0] b_mag_c;

  always_comb begin
    is_signed_c = (md_op == MD_MULT) || (md_op == MD_DIV);
    is_div_c    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    a_mag_c     = mag(rs_data, is_signed_c);
    b_mag_c     = mag(rt_data, is_signed_c);
  end

  // One shift-add or restoring-division step, plus sign-corrected final result
  logic [DATA_W:0]   mul_sum_c;
  logic [ACC_W-1:0]  mul_next_c;
  logic [DATA_W:0]   rem_sh_c;
  logic              rem_ge_c;
  logic [DATA_W-1:0] rem_diff_c;
  logic [ACC_W-1:0]  div_next_c;
  logic [ACC_W-1:0]  step_acc_c;
  hilo_t             res_c;

  always_comb begin
    // Multiply: conditionally add multiplicand to the upper half, shift right.
    mul_sum_c  = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : (DATA_W+1)'(0));
    mul_next_c = {mul_sum_c, acc[DATA_W-1:1]};

    // Divide: shift remainder left taking the next dividend bit, subtract if it fits.
    // The shifted remainder can need DATA_W+1 bits; the difference always fits DATA_W.
    rem_sh_c   = acc[ACC_W-1:DATA_W-1];
    rem_ge_c   = (rem_sh_c >= {1'b0, opb});
    rem_diff_c = rem_sh_c[DATA_W-1:0] - opb;
    div_next_c = {(rem_ge_c ? rem_diff_c : rem_sh_c[DATA_W-1:0]),
                  acc[DATA_W-2:0], rem_ge_c};

    step_acc_c = (state == ST_DIV) ? div_next_c : mul_next_c;

    if (state == ST_DIV) begin
      res_c.lo = neg_q ? (~div_next_c[DATA_W-1:0] + DATA_W'(1)) : div_next_c[DATA_W-1:0];
      res_c.hi = neg_r ? (~div_next_c[ACC_W-1:DATA_W] + DATA_W'(1))
                       : div_next_c[ACC_W-1:DATA_W];
    end else begin
      res_c = neg_q ? hilo_t'(~mul_next_c + ACC_W'(1)) : hilo_t'(mul_next_c);
    end
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk) begin
    if (reset_) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= DISABLED;
      done  <= DISABLED;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt   <= '0;
            neg_q <= is_signed_c && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
            neg_r <= is_signed_c && rs_data[DATA_W-1];
            busy  <= ENABLED;
            if (is_div_c) begin
              acc <= {DATA_W'(0), a_mag_c};
              opb <= b_mag_c;
              if (rt_data == '0) begin
                // Divide by zero completes immediately; result beats a same-cycle MTHI/MTLO.
                hi    <= rs_data;
                lo    <= '1;
                state <= ST_DONE;
                done  <= ENABLED;
              end else begin
                state <= ST_DIV;
              end
            end else begin
              acc   <= {DATA_W'(0), b_mag_c};
              opb   <= a_mag_c;
              state <= ST_MUL;
            end
          end
        end

        ST_MUL, ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= DISABLED;
          end else begin
            acc <= step_acc_c;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(MD_ITER - 1)) begin
              hi    <= res_c.hi;
              lo    <= res_c.lo;
              state <= ST_DONE;
              done  <= ENABLED;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= DISABLED;
          done  <= DISABLED;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= DISABLED;
          done  <= DISABLED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;

  logic        clk;
  logic        reset_;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total  = 0;
  int passed = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  ex_muldiv dut (
    .clk     (clk),
    .reset_  (reset_),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue one operation and run until busy drops (bounded), counting busy cycles and done pulses.
  // With inject set, a conflicting start is raised on the fifth busy cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int bc, output int dc);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    step();
    start = 1'b0; rs_data = 32'hA5A5_A5A5; rt_data = 32'h0000_0001;
    bc = 0; dc = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      bc++;
      if (done) dc++;
      if (inject && bc == 5) begin
        start = 1'b1; md_op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd3;
      end
      step();
      start = 1'b0;
    end
  endtask

  int bc;
  int dc;
  int seen_done;

  initial begin
    reset_ = 1'b1; start = 1'b0; md_op = 2'b00; rs_data = '0; rt_data = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    step(); step();
    reset_ = 1'b0;
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // MULT -1 * 2
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, bc, dc);
    check("mult_busy_cycles", 32'(bc), 32'd33);
    check("mult_done_pulses", 32'(dc), 32'd1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);

    // MULTU max * max
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc, dc);
    check("multu_busy_cycles", 32'(bc), 32'd33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2 with an ignored second start
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, bc, dc);
    check("div_busy_cycles", 32'(bc), 32'd33);
    check("div_done_pulses", 32'(dc), 32'd1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    step();
    check("div_no_restart", 32'(busy), 32'd0);

    // DIV 7 / -2: quotient -3, remainder +1
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, bc, dc);
    check("div_negdiv_lo", lo, 32'hFFFF_FFFD);
    check("div_negdiv_hi", hi, 32'd1);

    // Signed overflow 0x8000_0000 / -1
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc, dc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // DIVU 7 / 0
    run_op(OP_DIVU, 32'd7, 32'd0, 1'b0, bc, dc);
    check("div0_busy_cycles", 32'(bc), 32'd1);
    check("div0_done_pulses", 32'(dc), 32'd1);
    check("div0_hi", hi, 32'd7);
    check("div0_lo", lo, 32'hFFFF_FFFF);

    // MTHI in idle, then DIVU 100/3 flushed at count 10 (MTLO while busy ignored)
    hi_we = 1'b1; wdata = 32'h0000_1234;
    step();
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h0000_1234);
    start = 1'b1; md_op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd3;
    step();
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen_done++;
      if (i == 3) begin lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      step();
      lo_we = 1'b0;
    end
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (done) seen_done++;
      step();
    end
    check("flush_no_done", 32'(seen_done), 32'd0);
    check("flush_hi_kept", hi, 32'h0000_1234);
    check("busy_mtlo_ignored", lo, 32'hFFFF_FFFF);

    // MTLO in the same cycle as an accepted start, overwritten by the result
    start = 1'b1; md_op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd5;
    lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    step();
    start = 1'b0; lo_we = 1'b0;
    check("same_cycle_mtlo", lo, 32'h0BAD_F00D);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      step();
    end
    check("same_cycle_res_hi", hi, 32'd0);
    check("same_cycle_res_lo", lo, 32'd15);

    // Reset at count 20 of MULT
    start = 1'b1; md_op = OP_MULT; rs_data = 32'd9; rt_data = 32'd9;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    reset_ = 1'b1;
    step();
    reset_ = 1'b0;
    check("midop_reset_busy", 32'(busy), 32'd0);
    check("midop_reset_hi", hi, 32'd0);
    check("midop_reset_lo", lo, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen_done++;
      step();
    end
    check("midop_reset_no_done", 32'(seen_done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
